// File: rtl/gate_pkg.sv
// Shared encodings for the gate sweep checker: gate function codes and FSM states.
// Also used by benches that need to decode the checker's debug state.
package gate_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_AND  = 3'd0;
  localparam logic [MODE_W-1:0] MODE_OR   = 3'd1;
  localparam logic [MODE_W-1:0] MODE_NAND = 3'd2;
  localparam logic [MODE_W-1:0] MODE_NOR  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_XOR  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_XNOR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic mode_legal(input logic [MODE_W-1:0] m);
    return (m <= MODE_XNOR);
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for an N-input gate: reduction AND/OR/XOR and their inverses.
// Illegal mode codes produce 0; the checker never sweeps with them.
module gate_ref_model
  import gate_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0]   vec,
  input  logic [MODE_W-1:0] mode,
  output logic              exp_z
);

  always_comb begin
    exp_z = 1'b0;
    case (mode)
      MODE_AND:  exp_z = &vec;
      MODE_OR:   exp_z = |vec;
      MODE_NAND: exp_z = ~&vec;
      MODE_NOR:  exp_z = ~|vec;
      MODE_XOR:  exp_z = ^vec;
      MODE_XNOR: exp_z = ~^vec;
      default:   exp_z = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep engine: walks stim through every input vector, waits SETTLE cycles,
// compares dut_z against the reference gate and accumulates a pass/fail verdict.
module gate_sweep_checker
  import gate_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [MODE_W-1:0] mode,
  input  logic              dut_z,
  output logic [N_IN-1:0]   stim,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              mode_err,
  output logic [ERR_W-1:0]  err_count,
  output logic [N_IN-1:0]   fail_vec,
  output logic              fail_vld,
  output state_t            dbg_state
);

  // Handshake: start is a one-cycle request accepted only in IDLE or DONE (abort wins);
  // busy is high for the whole sweep; done is a level held until the next accepted start or abort.

  localparam logic [N_IN-1:0] ALL_ONES    = '1;
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

  state_t            state, state_nxt;
  logic [3:0]        settle_cnt;
  logic [MODE_W-1:0] mode_q;
  logic              exp_z;
  logic              mismatch;
  logic              last_vec;

  gate_ref_model #(.N_IN(N_IN)) u_ref (
    .vec   (stim),
    .mode  (mode_q),
    .exp_z (exp_z)
  );

  assign mismatch  = (dut_z != exp_z);
  assign last_vec  = (stim == ALL_ONES);
  assign busy      = (state == ST_SETTLE) || (state == ST_CHECK);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start) state_nxt = mode_legal(mode) ? ST_SETTLE : ST_DONE;
        ST_SETTLE:        if (settle_cnt == SETTLE_LAST) state_nxt = ST_CHECK;
        ST_CHECK:         state_nxt = last_vec ? ST_DONE : ST_SETTLE;
        default:          state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim       <= '0;
      settle_cnt <= '0;
      mode_q     <= MODE_AND;
      pass       <= 1'b0;
      mode_err   <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
      fail_vld   <= 1'b0;
    end else if (abort) begin
      // Result registers are kept so a host can still inspect a partial run.
      stim       <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (mode_legal(mode)) begin
              mode_q     <= mode;
              stim       <= '0;
              settle_cnt <= '0;
              pass       <= 1'b0;
              mode_err   <= 1'b0;
              err_count  <= '0;
              fail_vec   <= '0;
              fail_vld   <= 1'b0;
            end else begin
              pass     <= 1'b0;
              mode_err <= 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          settle_cnt <= (settle_cnt == SETTLE_LAST) ? 4'd0 : settle_cnt + 4'd1;
        end
        ST_CHECK: begin
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + ERR_W'(1);
            if (!fail_vld) begin
              fail_vec <= stim;
              fail_vld <= 1'b1;
            end
          end
          // Verdict must include this cycle's compare, which has not reached err_count yet.
          if (last_vec) pass <= (err_count == '0) && !mismatch;
          else          stim <= stim + N_IN'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
